// File: rtl/sort_arbiter.sv
// ============================================================================
// Module  : sort_arbiter
// Brief   : Round-robin front end that shares one in-order sorter among
//           several requesters and routes results back by a tag FIFO.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sort_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_ELEMS  = 4,
  parameter int MAX_OUT    = 4,
  localparam int VW = DATA_WIDTH * NUM_ELEMS,
  localparam int IW = $clog2(NUM_REQ),
  localparam int OW = $clog2(MAX_OUT) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_tvalid,
  output logic [NUM_REQ-1:0]    req_tready,
  input  logic [NUM_REQ*VW-1:0] req_tdata,
  output logic                  srt_src_tvalid,
  input  logic                  srt_src_tready,
  output logic [VW-1:0]         srt_src_tdata,
  input  logic                  srt_dest_tvalid,
  output logic                  srt_dest_tready,
  input  logic [VW-1:0]         srt_dest_tdata,
  output logic [NUM_REQ-1:0]    rsp_tvalid,
  input  logic [NUM_REQ-1:0]    rsp_tready,
  output logic [VW-1:0]         rsp_tdata,
  output logic [IW-1:0]         rsp_tid,
  output logic [OW-1:0]         outstanding,
  output logic                  err_orphan
);

  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic          err_orphan_q, err_orphan_d;
  logic [IW-1:0] tag_mem_q [MAX_OUT];

  logic               w_full, w_empty, w_any_valid, w_push, w_pop;
  logic               w_hi_found, w_lo_found;
  logic [IW-1:0]      w_hi_idx, w_lo_idx, w_grant_idx, w_head;
  logic [NUM_REQ-1:0] w_grant;
  logic [VW-1:0]      w_src_data;

  assign w_full      = (outstanding_q == OW'(MAX_OUT));
  assign w_empty     = (outstanding_q == '0);
  assign w_any_valid = |req_tvalid;

  // Search downward so the last hit is the lowest index in each half:
  // "hi" is at/after rr_ptr, "lo" is the wrapped-around region before it.
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_tvalid[i]) begin
        if (IW'(i) >= rr_ptr_q) begin
          w_hi_found = 1'b1;
          w_hi_idx   = IW'(i);
        end else begin
          w_lo_found = 1'b1;
          w_lo_idx   = IW'(i);
        end
      end
    end
    w_grant_idx = w_hi_found ? w_hi_idx : w_lo_idx;
    w_grant     = '0;
    w_grant[w_grant_idx] = w_hi_found | w_lo_found;
  end

  always_comb begin
    w_src_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_idx == IW'(i)) begin
        w_src_data = req_tdata[i*VW +: VW];
      end
    end
  end

  // Issue is gated only by full (never by a same-cycle pop) so there is no
  // combinational path from rsp_tready back to req_tready.
  assign srt_src_tvalid = rst_n && w_any_valid && !w_full;
  assign srt_src_tdata  = w_src_data;
  assign req_tready     = (rst_n && srt_src_tready && !w_full) ? w_grant : '0;
  assign w_push         = srt_src_tvalid && srt_src_tready;

  assign w_head = tag_mem_q[rd_ptr_q];

  always_comb begin
    rsp_tvalid = '0;
    if (!w_empty) begin
      rsp_tvalid[w_head] = srt_dest_tvalid;
    end
  end

  assign srt_dest_tready = !w_empty && rsp_tready[w_head];
  assign rsp_tid         = w_head;
  assign rsp_tdata       = srt_dest_tdata;
  assign w_pop           = srt_dest_tvalid && srt_dest_tready;

  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    outstanding_d = outstanding_q;
    err_orphan_d  = err_orphan_q | (srt_dest_tvalid && w_empty);
    if (w_push) begin
      rr_ptr_d = (w_grant_idx == IW'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({w_push, w_pop})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      outstanding_q <= '0;
      err_orphan_q  <= 1'b0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      outstanding_q <= outstanding_d;
      err_orphan_q  <= err_orphan_d;
    end
  end

  // Tag storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (w_push) begin
      tag_mem_q[wr_ptr_q] <= w_grant_idx;
    end
  end

  assign outstanding = outstanding_q;
  assign err_orphan  = err_orphan_q;

endmodule

`default_nettype wire

// File: tb/tb_sort_arbiter.sv
// ============================================================================
// Module  : tb_sort_arbiter
// Brief   : Scoreboard bench for sort_arbiter with a behavioural sorter model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sort_arbiter;

  localparam int NR = 2;
  localparam int VW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_tvalid, req_tready;
  logic [NR*VW-1:0] req_tdata;
  logic            srt_src_tvalid, srt_src_tready;
  logic [VW-1:0]   srt_src_tdata;
  logic            srt_dest_tvalid, srt_dest_tready;
  logic [VW-1:0]   srt_dest_tdata;
  logic [NR-1:0]   rsp_tvalid, rsp_tready;
  logic [VW-1:0]   rsp_tdata;
  logic [0:0]      rsp_tid;
  logic [2:0]      outstanding;
  logic            err_orphan;

  always #5 clk = ~clk;

  sort_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(8), .NUM_ELEMS(4), .MAX_OUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_tvalid(req_tvalid), .req_tready(req_tready), .req_tdata(req_tdata),
    .srt_src_tvalid(srt_src_tvalid), .srt_src_tready(srt_src_tready),
    .srt_src_tdata(srt_src_tdata),
    .srt_dest_tvalid(srt_dest_tvalid), .srt_dest_tready(srt_dest_tready),
    .srt_dest_tdata(srt_dest_tdata),
    .rsp_tvalid(rsp_tvalid), .rsp_tready(rsp_tready), .rsp_tdata(rsp_tdata),
    .rsp_tid(rsp_tid), .outstanding(outstanding), .err_orphan(err_orphan)
  );

  logic [VW-1:0] q0[$], q1[$], srt_q[$];
  logic [VW-1:0] exp_src[$], exp_rsp0[$], exp_rsp1[$];
  logic          src_rdy, dest_en, orphan_force;
  logic [NR-1:0] rsp_rdy;
  int            n_vec = 0;
  int            n_err = 0;

  function automatic logic [31:0] sort4(input logic [31:0] v);
    logic [7:0] b [4];
    logic [7:0] t;
    for (int i = 0; i < 4; i++) b[i] = v[i*8 +: 8];
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3 - i; j++) begin
        if (b[j] > b[j+1]) begin
          t = b[j]; b[j] = b[j+1]; b[j+1] = t;
        end
      end
    end
    return {b[3], b[2], b[1], b[0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task drive();
    req_tvalid[0]   = (q0.size() != 0);
    req_tvalid[1]   = (q1.size() != 0);
    req_tdata[31:0] = (q0.size() != 0) ? q0[0] : '0;
    req_tdata[63:32] = (q1.size() != 0) ? q1[0] : '0;
    srt_src_tready  = src_rdy;
    srt_dest_tvalid = ((srt_q.size() != 0) && dest_en) || orphan_force;
    srt_dest_tdata  = (srt_q.size() != 0) ? srt_q[0] : '0;
    rsp_tready      = rsp_rdy;
  endtask

  task automatic send(input int r, input logic [31:0] v, input logic [31:0] sorted);
    if (r == 0) begin
      q0.push_back(v);
      exp_rsp0.push_back(sorted);
    end else begin
      q1.push_back(v);
      exp_rsp1.push_back(sorted);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((exp_src.size() != 0 || exp_rsp0.size() != 0 || exp_rsp1.size() != 0) && t < 200) begin
      @(posedge clk);
      t++;
    end
    #2;
    chk({name, "_drain_timeout"}, (t >= 200), 1'b0);
  endtask

  // Requester sources and in-order sorter model: handshakes are sampled on
  // the falling edge and retired just after the following rising edge.
  initial begin : bfm
    logic          s_hs, d_hs;
    logic [NR-1:0] r_hs;
    logic [VW-1:0] s_data;
    forever begin
      @(negedge clk);
      s_hs   = srt_src_tvalid && srt_src_tready;
      s_data = srt_src_tdata;
      d_hs   = srt_dest_tvalid && srt_dest_tready;
      r_hs   = req_tvalid & req_tready;
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (r_hs[0] && q0.size() != 0) void'(q0.pop_front());
        if (r_hs[1] && q1.size() != 0) void'(q1.pop_front());
        if (d_hs && srt_q.size() != 0) void'(srt_q.pop_front());
        if (s_hs) srt_q.push_back(sort4(s_data));
      end
      drive();
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (srt_src_tvalid && srt_src_tready) begin
          chk("src_expected", (exp_src.size() != 0), 1'b1);
          if (exp_src.size() != 0) chk("src_data", srt_src_tdata, exp_src.pop_front());
        end
        if (rsp_tvalid != '0) chk("rsp_onehot", rsp_tvalid, 2'b01 << rsp_tid);
        if (rsp_tvalid[0] && rsp_tready[0]) begin
          chk("rsp0_tid", rsp_tid, 1'b0);
          chk("rsp0_expected", (exp_rsp0.size() != 0), 1'b1);
          if (exp_rsp0.size() != 0) chk("rsp0_data", rsp_tdata, exp_rsp0.pop_front());
        end
        if (rsp_tvalid[1] && rsp_tready[1]) begin
          chk("rsp1_tid", rsp_tid, 1'b1);
          chk("rsp1_expected", (exp_rsp1.size() != 0), 1'b1);
          if (exp_rsp1.size() != 0) chk("rsp1_data", rsp_tdata, exp_rsp1.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time %0t reached without finishing", $time);
    $fatal(1, "watchdog");
  end

  initial begin : main
    rst_n = 1'b0; src_rdy = 1'b1; dest_en = 1'b1; orphan_force = 1'b0; rsp_rdy = 2'b11;

    // Reset state with both requesters already valid; req0 wins first.
    send(0, 32'h11223344, 32'h44332211);
    send(1, 32'h0A0C0B09, 32'h0C0B0A09);
    exp_src.push_back(32'h11223344);
    exp_src.push_back(32'h0A0C0B09);
    drive();
    #3;
    chk("rst_src_tvalid", srt_src_tvalid, 1'b0);
    chk("rst_req_tready", req_tready, 2'b00);
    chk("rst_rsp_tvalid", rsp_tvalid, 2'b00);
    chk("rst_dest_tready", srt_dest_tready, 1'b0);
    chk("rst_outstanding", outstanding, 3'd0);
    chk("rst_err_orphan", err_orphan, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    wait_drain("t0");
    chk("t0_outstanding", outstanding, 3'd0);

    // Single requester, two vectors in order.
    send(0, 32'h04030201, 32'h04030201);
    send(0, 32'h01020304, 32'h04030201);
    exp_src.push_back(32'h04030201);
    exp_src.push_back(32'h01020304);
    drive();
    wait_drain("single");
    chk("single_outstanding", outstanding, 3'd0);

    // Contention: rr_ptr is 1 here, so grants run 1,0,1,0.
    send(0, 32'h10203040, 32'h40302010);
    send(0, 32'h50607080, 32'h80706050);
    send(1, 32'h00FF0000, 32'hFF000000);
    send(1, 32'h0000FF01, 32'hFF010000);
    exp_src.push_back(32'h00FF0000);
    exp_src.push_back(32'h10203040);
    exp_src.push_back(32'h0000FF01);
    exp_src.push_back(32'h50607080);
    drive();
    wait_drain("contend");

    // Full: sorter output stalled, five offered, four accepted.
    dest_en = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      send(0, 32'(k) << 8, 32'(k) << 24);
      exp_src.push_back(32'(k) << 8);
    end
    drive();
    wait_cyc(8);
    @(negedge clk);
    chk("full_outstanding", outstanding, 3'd4);
    chk("full_src_tvalid", srt_src_tvalid, 1'b0);
    chk("full_req_tready", req_tready, 2'b00);
    wait_cyc(1);
    dest_en = 1'b1;
    drive();
    @(negedge clk);
    chk("full_pop_dest_tready", srt_dest_tready, 1'b1);
    chk("full_pop_req_tready", req_tready, 2'b00);
    wait_cyc(1);
    dest_en = 1'b0;
    drive();
    @(negedge clk);
    chk("full_resume_outstanding", outstanding, 3'd3);
    chk("full_resume_req_tready", req_tready, 2'b01);
    wait_cyc(1);
    dest_en = 1'b1;
    drive();
    wait_drain("full");

    // Backpressure: req1 owns the head and is not ready.
    rsp_rdy = 2'b01;
    send(1, 32'h00050000, 32'h05000000);
    send(0, 32'h00000600, 32'h06000000);
    exp_src.push_back(32'h00050000);
    exp_src.push_back(32'h00000600);
    drive();
    wait_cyc(5);
    @(negedge clk);
    chk("bp_outstanding", outstanding, 3'd2);
    chk("bp_rsp_tvalid", rsp_tvalid, 2'b10);
    chk("bp_rsp_tid", rsp_tid, 1'b1);
    chk("bp_dest_tready", srt_dest_tready, 1'b0);
    chk("bp_rsp_tdata", rsp_tdata, 32'h05000000);
    wait_cyc(1);
    rsp_rdy = 2'b11;
    drive();
    wait_drain("bp");

    // Orphan result with an empty tag FIFO.
    wait_cyc(1);
    orphan_force = 1'b1;
    drive();
    @(negedge clk);
    chk("orph_before", err_orphan, 1'b0);
    chk("orph_rsp_tvalid", rsp_tvalid, 2'b00);
    chk("orph_dest_tready", srt_dest_tready, 1'b0);
    wait_cyc(1);
    orphan_force = 1'b0;
    drive();
    @(negedge clk);
    chk("orph_set", err_orphan, 1'b1);
    wait_cyc(3);
    @(negedge clk);
    chk("orph_sticky", err_orphan, 1'b1);

    // Reset with three vectors in flight.
    wait_cyc(1);
    dest_en = 1'b0;
    send(0, 32'h00000700, 32'h07000000);
    send(0, 32'h00000800, 32'h08000000);
    send(0, 32'h00000900, 32'h09000000);
    exp_src.push_back(32'h00000700);
    exp_src.push_back(32'h00000800);
    exp_src.push_back(32'h00000900);
    drive();
    wait_cyc(6);
    @(negedge clk);
    chk("pre_rst_outstanding", outstanding, 3'd3);
    #1 rst_n = 1'b0;
    q0.delete(); q1.delete(); srt_q.delete();
    exp_src.delete(); exp_rsp0.delete(); exp_rsp1.delete();
    dest_en = 1'b1;
    drive();
    #1;
    chk("mid_rst_outstanding", outstanding, 3'd0);
    chk("mid_rst_err_orphan", err_orphan, 1'b0);
    chk("mid_rst_dest_tready", srt_dest_tready, 1'b0);
    send(1, 32'h0000AB00, 32'hAB000000);
    exp_src.push_back(32'h0000AB00);
    drive();
    #1;
    chk("mid_rst_src_tvalid", srt_src_tvalid, 1'b0);
    chk("mid_rst_req_tready", req_tready, 2'b00);
    wait_cyc(2);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_grant", req_tready, 2'b10);
    wait_drain("post_rst");
    chk("post_rst_outstanding", outstanding, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sort_arbiter.md
SORT_ARBITER -- requirements
Module: sort_arbiter

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- NUM_REQ, 2, number of requester streams (2..8).
- DATA_WIDTH, 8, bits per element.
- NUM_ELEMS, 4, elements per vector.
- MAX_OUT, 4, maximum vectors in flight inside the shared sorter (power of 2).
REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning (VW = DATA_WIDTH*NUM_ELEMS, IW = clog2(NUM_REQ)).
- clk, in, 1, the only clock.
- rst_n, in, 1, asynchronous active-low reset.
- req_tvalid, in, NUM_REQ, per-requester input valid.
- req_tready, out, NUM_REQ, per-requester input ready.
- req_tdata, in, NUM_REQ*VW, flattened vectors (requester i at [i*VW +: VW]).
- srt_src_tvalid, out, 1, vector valid to the sorter.
- srt_src_tready, in, 1, sorter ready.
- srt_src_tdata, out, VW, vector to the sorter.
- srt_dest_tvalid, in, 1, sorted-vector valid from the sorter.
- srt_dest_tready, out, 1, ready to the sorter.
- srt_dest_tdata, in, VW, sorted vector from the sorter.
- rsp_tvalid, out, NUM_REQ, per-requester result valid.
- rsp_tready, in, NUM_REQ, per-requester result ready.
- rsp_tdata, out, VW, shared result bus.
- rsp_tid, out, IW, index of the requester owning rsp_tdata.
- outstanding, out, clog2(MAX_OUT)+1, number of vectors in flight.
- err_orphan, out, 1, sticky: sorter output arrived with no tag held.

Function
REQ-003 The sorter SHALL be in-order, so each accepted vector's requester ID SHALL be pushed into a tag FIFO of depth MAX_OUT on every srt_src handshake.
REQ-004 The tag FIFO head SHALL be popped on every srt_dest handshake.
REQ-005 Arbitration SHALL be round-robin per beat: grant goes to the first asserted req_tvalid at or after rr_ptr, wrapping modulo NUM_REQ.
REQ-006 On a srt_src handshake, rr_ptr SHALL become (granted index + 1) mod NUM_REQ; otherwise it SHALL hold.
REQ-007 full SHALL be (outstanding == MAX_OUT).
REQ-008 srt_src_tvalid SHALL equal (|req_tvalid) && !full, and SHALL NOT depend on srt_src_tready.
REQ-009 srt_src_tdata SHALL equal the granted requester's slice.
REQ-010 req_tready[i] SHALL equal grant[i] && srt_src_tready && !full; all non-granted bits SHALL be 0.
REQ-011 full SHALL block issue even when a pop occurs in the same cycle, leaving no combinational ready path from rsp to req.
REQ-012 With the FIFO non-empty and head = h:
- rsp_tvalid SHALL be one-hot at bit h, equal to srt_dest_tvalid.
- rsp_tid SHALL equal h.
- rsp_tdata SHALL equal srt_dest_tdata.
- srt_dest_tready SHALL equal rsp_tready[h].
REQ-013 A stalled requester SHALL stall the shared output; head-of-line blocking is accepted behaviour.
REQ-014 With the FIFO empty, rsp_tvalid SHALL be 0 and srt_dest_tready SHALL be 0.
REQ-015 If srt_dest_tvalid=1 while the FIFO is empty, err_orphan SHALL set the next cycle and hold until reset.
REQ-016 outstanding SHALL update as follows on each clock:
- +1 on push only.
- -1 on pop only.
- unchanged on simultaneous push and pop.
REQ-017 Pointer wrap SHALL be modulo MAX_OUT; outstanding SHALL never exceed MAX_OUT or underflow.
REQ-018 Latency through the arbiter SHALL be zero cycles in both directions; all added state is the tag FIFO, rr_ptr, outstanding and err_orphan.

Reset
REQ-019 While rst_n=0, asynchronously:
- rr_ptr=0, FIFO empty, outstanding=0, err_orphan=0.
- req_tready=0, srt_src_tvalid=0, rsp_tvalid=0, srt_dest_tready=0.
REQ-020 Reset mid-operation SHALL discard all tags; the integrator SHALL reset the sorter in the same cycle so that no orphan results appear.
REQ-021 After rst_n deasserts, the first grant SHALL go to the lowest-index valid requester.

Verification
REQ-022 Single requester: req0 sends 0x04030201 then 0x01020304 -> srt_src sees both in order, rsp_tvalid=01 and rsp_tid=0 for each, outstanding returns to 0.
REQ-023 Contention: NUM_REQ=2, both valid continuously, sorter always ready -> grants alternate 0,1,0,1 and results route to the matching requester.
REQ-024 Full: sorter dest stalled, 5 vectors offered -> 4 accepted, outstanding=4, req_tready=0 on the 5th until one pop, then issue resumes the following cycle.
REQ-025 Backpressure: head owned by req1 with rsp_tready[1]=0 -> srt_dest_tready=0 and the req0 result behind it is held.
REQ-026 Orphan: srt_dest_tvalid=1 with the FIFO empty -> err_orphan=1 the next cycle and stays 1 until rst_n=0.
REQ-027 Reset: assert rst_n=0 with outstanding=3 -> all outputs and counters clear immediately; after release, req1 alone valid is granted.
